// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results through to Writeback and runs
// LDB/LDW/STB/STW as req/ack data-memory transactions, stalling Execute meanwhile.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef OPC_LDB
`define OPC_LDB 2
`endif
`ifndef OPC_STB
`define OPC_STB 3
`endif
`ifndef OPC_LDW
`define OPC_LDW 6
`endif
`ifndef OPC_STW
`define OPC_STW 7
`endif

module memory_stage #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_EX_Valid,
    input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [DATA_W-1:0]        I_DestValue,
    input  logic [ADDR_W-1:0]        I_MARValue,
    input  logic [DATA_W-1:0]        I_MDRValue,
    input  logic                     I_RegWEn,
    input  logic                     I_CCWEn,
    input  logic [2:0]               I_CCValue,
    output logic                     O_MEMStallSignal,
    output logic                     O_DMemReq,
    output logic                     O_DMemWE,
    output logic [ADDR_W-1:0]        O_DMemAddr,
    output logic [DATA_W-1:0]        O_DMemWData,
    output logic [1:0]               O_DMemByteEn,
    input  logic                     I_DMemAck,
    input  logic [DATA_W-1:0]        I_DMemRData,
    output logic                     O_MEM_Valid,
    output logic [3:0]               O_DestRegIdx,
    output logic [DATA_W-1:0]        O_DestValue,
    output logic                     O_RegWEn,
    output logic                     O_CCWEn,
    output logic [2:0]               O_CCValue,
    output logic                     O_DMemErr
);

    localparam logic [`OPCODE_WIDTH-1:0] OP_LDB = `OPCODE_WIDTH'(`OPC_LDB);
    localparam logic [`OPCODE_WIDTH-1:0] OP_STB = `OPCODE_WIDTH'(`OPC_STB);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LDW = `OPCODE_WIDTH'(`OPC_LDW);
    localparam logic [`OPCODE_WIDTH-1:0] OP_STW = `OPCODE_WIDTH'(`OPC_STW);
    localparam logic [7:0]               TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              r_state, w_state;
    logic [7:0]          r_count, w_count;
    logic                r_is_load, w_is_load;
    logic                r_is_byte, w_is_byte;
    logic                r_lane, w_lane;
    logic [3:0]          r_dest, w_dest;
    logic                r_req, w_req;
    logic                r_we, w_we;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic [1:0]          r_byteen, w_byteen;
    logic                r_valid, w_valid;
    logic [3:0]          r_oidx, w_oidx;
    logic [DATA_W-1:0]   r_oval, w_oval;
    logic                r_oregwen, w_oregwen;
    logic                r_occwen, w_occwen;
    logic [2:0]          r_occ, w_occ;
    logic                r_err, w_err;

    logic                w_op_mem, w_op_store, w_op_byte;
    logic [7:0]          w_rbyte;
    logic [DATA_W-1:0]   w_load_val;
    logic [2:0]          w_load_cc;

    assign w_op_mem   = (I_Opcode == OP_LDB) || (I_Opcode == OP_LDW) ||
                        (I_Opcode == OP_STB) || (I_Opcode == OP_STW);
    assign w_op_store = (I_Opcode == OP_STB) || (I_Opcode == OP_STW);
    assign w_op_byte  = (I_Opcode == OP_LDB) || (I_Opcode == OP_STB);

    // LDB picks the high byte when the captured MAR was odd
    assign w_rbyte    = r_lane ? I_DMemRData[15:8] : I_DMemRData[7:0];
    assign w_load_val = r_is_byte ? {{(DATA_W-8){w_rbyte[7]}}, w_rbyte} : I_DMemRData;
    assign w_load_cc  = w_load_val[DATA_W-1] ? 3'b100 :
                        (w_load_val == '0)   ? 3'b010 : 3'b001;

    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_is_load = r_is_load;
        w_is_byte = r_is_byte;
        w_lane    = r_lane;
        w_dest    = r_dest;
        w_req     = r_req;
        w_we      = r_we;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_byteen  = r_byteen;
        w_valid   = 1'b0;
        w_oidx    = r_oidx;
        w_oval    = r_oval;
        w_oregwen = r_oregwen;
        w_occwen  = r_occwen;
        w_occ     = r_occ;
        w_err     = r_err;
        case (r_state)
            IDLE: begin
                if (I_EX_Valid && w_op_mem) begin
                    w_is_load = !w_op_store;
                    w_is_byte = w_op_byte;
                    w_lane    = I_MARValue[0];
                    w_dest    = I_DestRegIdx;
                    w_req     = 1'b1;
                    w_we      = w_op_store;
                    w_addr    = {I_MARValue[ADDR_W-1:1], 1'b0};
                    w_count   = '0;
                    w_state   = ACCESS;
                    if (w_op_store && w_op_byte) begin
                        w_wdata  = {(DATA_W/8){I_MDRValue[7:0]}};
                        w_byteen = I_MARValue[0] ? 2'b10 : 2'b01;
                    end else begin
                        w_wdata  = I_MDRValue;
                        w_byteen = 2'b11;
                    end
                end else if (I_EX_Valid) begin
                    w_valid   = 1'b1;
                    w_oidx    = I_DestRegIdx;
                    w_oval    = I_DestValue;
                    w_oregwen = I_RegWEn;
                    w_occwen  = I_CCWEn;
                    w_occ     = I_CCValue;
                end
            end
            ACCESS: begin
                // ack wins over a timeout firing on the same edge
                if (I_DMemAck) begin
                    w_req   = 1'b0;
                    w_state = IDLE;
                    w_valid = 1'b1;
                    w_oidx  = r_dest;
                    if (r_is_load) begin
                        w_oval    = w_load_val;
                        w_oregwen = 1'b1;
                        w_occwen  = 1'b1;
                        w_occ     = w_load_cc;
                    end else begin
                        w_oval    = '0;
                        w_oregwen = 1'b0;
                        w_occwen  = 1'b0;
                    end
                end else if (r_count == TO_LAST) begin
                    w_req     = 1'b0;
                    w_state   = IDLE;
                    w_valid   = 1'b1;
                    w_oidx    = r_dest;
                    w_oval    = '0;
                    w_oregwen = 1'b0;
                    w_occwen  = 1'b0;
                    w_err     = 1'b1;
                end else begin
                    w_count = r_count + 8'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_is_load <= 1'b0;
            r_is_byte <= 1'b0;
            r_lane    <= 1'b0;
            r_dest    <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_byteen  <= '0;
            r_valid   <= 1'b0;
            r_oidx    <= '0;
            r_oval    <= '0;
            r_oregwen <= 1'b0;
            r_occwen  <= 1'b0;
            r_occ     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_is_load <= w_is_load;
            r_is_byte <= w_is_byte;
            r_lane    <= w_lane;
            r_dest    <= w_dest;
            r_req     <= w_req;
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_byteen  <= w_byteen;
            r_valid   <= w_valid;
            r_oidx    <= w_oidx;
            r_oval    <= w_oval;
            r_oregwen <= w_oregwen;
            r_occwen  <= w_occwen;
            r_occ     <= w_occ;
            r_err     <= w_err;
        end
    end

    assign O_MEMStallSignal = (r_state == ACCESS);
    assign O_DMemReq        = r_req;
    assign O_DMemWE         = r_we;
    assign O_DMemAddr       = r_addr;
    assign O_DMemWData      = r_wdata;
    assign O_DMemByteEn     = r_byteen;
    assign O_MEM_Valid      = r_valid;
    assign O_DestRegIdx     = r_oidx;
    assign O_DestValue      = r_oval;
    assign O_RegWEn         = r_oregwen;
    assign O_CCWEn          = r_occwen;
    assign O_CCValue        = r_occ;
    assign O_DMemErr        = r_err;

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory stage between Execute and Writeback. It accepts one instruction per cycle from Execute. Non-memory instructions pass straight through to Writeback. LDB/LDW/STB/STW run a req/ack transaction on the data-memory port, and Execute is stalled until the access completes or times out. Loads produce the writeback value and condition code.

## Interface
- DATA_W, 16, register/data width
- ADDR_W, 16, data-memory byte address width
- TIMEOUT_CYCLES, 255, max cycles waiting for I_DMemAck before abort (1..255)

- I_CLOCK  in  1  stage clock; all state updates on falling edge
- I_RESET  in  1  reset, asynchronous, active-high
- I_EX_Valid  in  1  Execute output valid
- I_Opcode  in  `OPCODE_WIDTH  opcode from Execute
- I_DestRegIdx  in  4  destination register
- I_DestValue  in  DATA_W  ALU result (pass-through ops)
- I_MARValue  in  ADDR_W  memory byte address
- I_MDRValue  in  DATA_W  store data
- I_RegWEn / I_CCWEn  in  1 each  write enables (pass-through ops)
- I_CCValue  in  3  CC from Execute (pass-through ops)
- O_MEMStallSignal  out  1  combinational; high while state=ACCESS; Execute holds its outputs
- O_DMemReq  out  1  memory request
- O_DMemWE  out  1  1=store, 0=load
- O_DMemAddr  out  ADDR_W  word-aligned address, MAR with bit0 cleared
- O_DMemWData  out  DATA_W  write data
- O_DMemByteEn  out  2  lane enables; bit0=low byte
- I_DMemAck  in  1  access complete; sampled at falling edge
- I_DMemRData  in  DATA_W  read data, valid with ack
- O_MEM_Valid  out  1  output to Writeback valid
- O_DestRegIdx  out  4  destination register
- O_DestValue  out  DATA_W  writeback value
- O_RegWEn / O_CCWEn  out  1 each  write enables
- O_CCValue  out  3  CC, N=100, Z=010, P=001
- O_DMemErr  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, I_EX_Valid=0: next edge O_MEM_Valid=0.
- IDLE, valid non-memory op: next edge
  - O_MEM_Valid=1.
  - Copy DestRegIdx, DestValue, RegWEn, CCWEn and CCValue from the inputs.
- IDLE, valid memory op: next edge
  - Capture opcode, dest, MAR[0] and the wdata lane into internal registers.
  - O_DMemReq=1, O_DMemWE=store.
  - O_MEM_Valid=0, counter=0, go to ACCESS.
- Byte lane rules:
  - STB: ByteEn = MAR[0] ? 10 : 01; WData = {MDR[7:0], MDR[7:0]}.
  - STW: ByteEn=11, WData=MDR.
  - Loads: ByteEn=11.
  - LDW/STW ignore MAR[0] (aligned down).
- ACCESS, I_DMemAck=1 at an edge: on that edge
  - Req=0, go to IDLE, O_MEM_Valid=1.
  - LDW: DestValue=RData.
  - LDB: DestValue = sign-extended RData byte selected by captured MAR[0].
  - Loads: RegWEn=1, CCWEn=1, CC from the DestValue sign/zero.
  - Stores: RegWEn=0, CCWEn=0, DestValue=0.
- ACCESS, no ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack:
  - Req=0, go to IDLE, O_MEM_Valid=1.
  - RegWEn=0, CCWEn=0.
  - O_DMemErr=1, held until reset.
- I_DMemAck while IDLE: ignored.
- Inputs are not sampled in ACCESS. Execute must hold them while stalled.
- Req, WE, Addr, WData and ByteEn hold stable for the whole ACCESS state.

## Timing
- Reset (async, immediate): state=IDLE, counter=0.
- Every output resets to 0, including O_DMemReq, O_DMemErr and O_MEM_Valid.
- A reset mid-access drops Req immediately. The access is discarded and produces no O_MEM_Valid.
- Pass-through latency: 1 edge. Throughput: 1 per cycle.
- Memory-op latency: accepted at edge N, ack sampled at edge N+k (k≥1).
  - O_MEM_Valid is high for exactly one cycle after N+k.
  - The next instruction is accepted at N+k+1.
- O_MEMStallSignal is high from just after edge N until just after edge N+k.
- Timeout: Req is high for exactly TIMEOUT_CYCLES cycles, then drops.
- An ack on the same edge the timeout would fire counts as success: no error, normal result.

## Test plan
- Pass-through: ADD with DestValue=0x1234, RegWEn=1, Reg 3.
  - -> next cycle O_MEM_Valid=1, O_DestValue=0x1234, O_DestRegIdx=3, no Req.
  - Back-to-back ops give Valid every cycle.
- LDW at MAR=0x0041, ack after 3 cycles with RData=0x8001.
  - -> Addr=0x0040, ByteEn=11.
  - Stall high for 3 cycles.
  - O_DestValue=0x8001, CC=100, RegWEn=1.
- LDB at MAR=0x0011, RData=0x7F80 -> DestValue=0x007F, CC=001.
- LDB at MAR=0x0010, same RData -> DestValue=0xFF80, CC=100.
- STB at MAR=0x0021, MDR=0x00AB -> WE=1, ByteEn=10, WData=0xABAB; ack gives Valid=1 with RegWEn=0, CCWEn=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack:
  - -> Req high 4 cycles, then Valid=1 with RegWEn=0, O_DMemErr=1.
  - The error stays set through subsequent ops.
  - Assert I_RESET mid-ACCESS -> Req=0 and Err=0 immediately; no Valid afterwards.
